dcache_ctrl: RTL and testbench

- Data-cache responder sitting between the pipeline's MEM stage (initiator of memRd/memWr word requests) and the line-wide backing data memory.
- Direct-mapped, write-back, write-allocate cache of 16-bit words.
- Hits complete in the request cycle with no stall.
- Misses assert cpu_stall while an FSM writes back a dirty victim and then allocates the requested line over a ready-handshaked memory port.

---
 rtl/dcache_pkg.sv | 33 +++
 rtl/dcache_if.sv | 30 +++
 rtl/dcache_array.sv | 78 +++++++
 rtl/dcache_ctrl.sv | 118 +++++++++++
 tb/tb_dcache_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM encoding, address-field widths and the word-select helper.
package dcache_pkg;

   localparam int ADDR_W    = 16;
   localparam int WORD_W    = 16;
   localparam int DEF_LINES = 8;
   localparam int DEF_WPL   = 4;
   localparam int DEF_OFF_W = $clog2(DEF_WPL);
   localparam int DEF_IDX_W = $clog2(DEF_LINES);
   localparam int DEF_TAG_W = ADDR_W - DEF_IDX_W - DEF_OFF_W;

   // Widest line the helper handles; callers zero-extend their narrower lines.
   localparam int MAX_WPL    = 64;
   localparam int MAX_OFF_W  = $clog2(MAX_WPL);
   localparam int MAX_LINE_W = WORD_W * MAX_WPL;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WB    = 2'b01,
      ALLOC = 2'b10
   } state_e;

   function automatic int tag_w(input int lines, input int wpl);
      return ADDR_W - $clog2(lines) - $clog2(wpl);
   endfunction

   function automatic logic [WORD_W-1:0] word_sel(input logic [MAX_LINE_W-1:0] line,
                                                   input logic [MAX_OFF_W-1:0]  off);
      return line[off*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side request port and line-wide backing-memory port of the data cache.
interface dcache_if import dcache_pkg::*; #(
   parameter int WPL = DEF_WPL
) ();
   localparam int OFF_W  = $clog2(WPL);
   localparam int LINE_W = WORD_W * WPL;

   logic [ADDR_W-1:0]       cpu_addr;
   logic                    cpu_re;
   logic                    cpu_we;
   logic [WORD_W-1:0]       cpu_wdata;
   logic [WORD_W-1:0]       cpu_rdata;
   logic                    cpu_stall;
   logic [ADDR_W-OFF_W-1:0] mem_addr;
   logic                    mem_re;
   logic                    mem_we;
   logic [LINE_W-1:0]       mem_wdata;
   logic [LINE_W-1:0]       mem_rdata;
   logic                    mem_rdy;

   modport slave (
      input  cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_rdata, mem_rdy,
      output cpu_rdata, cpu_stall, mem_addr, mem_re, mem_we, mem_wdata
   );

   modport master (
      output cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_rdata, mem_rdy,
      input  cpu_rdata, cpu_stall, mem_addr, mem_re, mem_we, mem_wdata
   );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: asynchronous read by index, synchronous
// word store or line fill, asynchronous clear of the valid and dirty bits.
module dcache_array import dcache_pkg::*; #(
   parameter int LINES = DEF_LINES,
   parameter int WPL   = DEF_WPL,
   localparam int IDX_W  = $clog2(LINES),
   localparam int OFF_W  = $clog2(WPL),
   localparam int TAG_W  = tag_w(LINES, WPL),
   localparam int LINE_W = WORD_W * WPL
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  idx,
   output logic [TAG_W-1:0]  tag_o,
   output logic              valid_o,
   output logic              dirty_o,
   output logic [LINE_W-1:0] line_o,
   input  logic              wr_en,
   input  logic [OFF_W-1:0]  wr_off,
   input  logic [WORD_W-1:0] wr_word,
   input  logic              fill_en,
   input  logic [TAG_W-1:0]  fill_tag,
   input  logic [LINE_W-1:0] fill_line
);

   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINE_W-1:0] data_q [LINES];
   logic [LINES-1:0]  valid_q, valid_d;
   logic [LINES-1:0]  dirty_q, dirty_d;
   logic [LINE_W-1:0] merged_line;
   logic [LINE_W-1:0] line_d;

   assign tag_o   = tag_q[idx];
   assign valid_o = valid_q[idx];
   assign dirty_o = dirty_q[idx];
   assign line_o  = data_q[idx];

   // Store merges the new word into the current line; other words pass through.
   generate
      for (genvar gi = 0; gi < WPL; gi++) begin : g_merge
         assign merged_line[gi*WORD_W +: WORD_W] =
            (wr_off == OFF_W'(gi)) ? wr_word : line_o[gi*WORD_W +: WORD_W];
      end
   endgenerate

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      line_d  = merged_line;
      if (fill_en) begin
         valid_d[idx] = 1'b1;
         dirty_d[idx] = 1'b0;
         line_d       = fill_line;
      end else if (wr_en) begin
         dirty_d[idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_en || wr_en) begin
         data_q[idx] <= line_d;
      end
      if (fill_en) begin
         tag_q[idx] <= fill_tag;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache: hit path, miss FSM
// (IDLE -> WB -> ALLOC) and backing-memory port muxing.
module dcache_ctrl import dcache_pkg::*; #(
   parameter int LINES = DEF_LINES,
   parameter int WPL   = DEF_WPL
) (
   input  logic     clk,
   input  logic     rst_n,
   dcache_if.slave  bus
);

   localparam int IDX_W  = $clog2(LINES);
   localparam int OFF_W  = $clog2(WPL);
   localparam int TAG_W  = tag_w(LINES, WPL);
   localparam int LINE_W = WORD_W * WPL;

   state_e state_q, state_d;

   logic [OFF_W-1:0]  off;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [TAG_W-1:0]  arr_tag;
   logic              arr_valid;
   logic              arr_dirty;
   logic [LINE_W-1:0] arr_line;
   logic [WORD_W-1:0] hit_word;
   logic              req;
   logic              hit;
   logic              wr_en;
   logic              fill_en;

   assign off = bus.cpu_addr[OFF_W-1:0];
   assign idx = bus.cpu_addr[OFF_W +: IDX_W];
   assign tag = bus.cpu_addr[ADDR_W-1 -: TAG_W];
   assign req = bus.cpu_re | bus.cpu_we;
   assign hit = arr_valid && (arr_tag == tag);

   assign hit_word = word_sel(MAX_LINE_W'(arr_line), MAX_OFF_W'(off));

   dcache_array #(
      .LINES (LINES),
      .WPL   (WPL)
   ) u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .idx       (idx),
      .tag_o     (arr_tag),
      .valid_o   (arr_valid),
      .dirty_o   (arr_dirty),
      .line_o    (arr_line),
      .wr_en     (wr_en),
      .wr_off    (off),
      .wr_word   (bus.cpu_wdata),
      .fill_en   (fill_en),
      .fill_tag  (tag),
      .fill_line (bus.mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs are gated by rst_n so a reset mid-miss drops the memory
   // request and stall at once, without waiting for a clock edge.
   always_comb begin
      state_d       = state_q;
      bus.cpu_stall = 1'b0;
      bus.cpu_rdata = '0;
      bus.mem_re    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      wr_en         = 1'b0;
      fill_en       = 1'b0;
      if (rst_n) begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  if (hit) begin
                     if (bus.cpu_we) begin
                        wr_en = 1'b1;
                     end else begin
                        bus.cpu_rdata = hit_word;
                     end
                  end else begin
                     bus.cpu_stall = 1'b1;
                     state_d       = (arr_valid && arr_dirty) ? WB : ALLOC;
                  end
               end
            end
            WB: begin
               bus.cpu_stall = 1'b1;
               bus.mem_we    = 1'b1;
               bus.mem_addr  = {arr_tag, idx};
               bus.mem_wdata = arr_line;
               if (bus.mem_rdy) begin
                  state_d = ALLOC;
               end
            end
            ALLOC: begin
               bus.cpu_stall = 1'b1;
               bus.mem_re    = 1'b1;
               bus.mem_addr  = {tag, idx};
               if (bus.mem_rdy) begin
                  fill_en = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: miss fill, write hit, dirty write-back,
// clean eviction, long write-back hold and asynchronous reset mid-fill.
module tb_dcache_ctrl;
   import dcache_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dcache_if #(.WPL(4)) bus ();

   dcache_ctrl #(
      .LINES (8),
      .WPL   (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks       = 0;
   int passed       = 0;
   int stall_cycles = 0;
   int we_cycles    = 0;
   int base_stall;
   int base_we;

   always @(negedge clk) begin
      if (bus.cpu_stall) stall_cycles++;
      if (bus.mem_we)    we_cycles++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
         $error("check %s failed", tag);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.cpu_addr  = '0;
      bus.cpu_re    = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_wdata = '0;
      bus.mem_rdata = '0;
      bus.mem_rdy   = 1'b0;

      // reset state
      #2;
      check("rst_stall",  64'(bus.cpu_stall), 64'h0);
      check("rst_mem_re", 64'(bus.mem_re),    64'h0);
      check("rst_mem_we", 64'(bus.mem_we),    64'h0);
      check("rst_rdata",  64'(bus.cpu_rdata), 64'h0);
      tick; tick;
      rst_n = 1'b1;

      // 1: cold read miss of 0x0012, fill on the 3rd ALLOC cycle
      base_stall = stall_cycles;
      base_we    = we_cycles;
      tick;
      bus.cpu_addr = 16'h0012;
      bus.cpu_re   = 1'b1;
      #1;
      check("t1_detect_stall", 64'(bus.cpu_stall), 64'h1);
      check("t1_detect_re",    64'(bus.mem_re),    64'h0);
      tick; #1;
      check("t1_alloc_re",   64'(bus.mem_re),   64'h1);
      check("t1_alloc_addr", 64'(bus.mem_addr), 64'h4);
      tick; tick;
      bus.mem_rdy   = 1'b1;
      bus.mem_rdata = 64'h4444_3333_2222_1111;
      tick;
      bus.mem_rdy = 1'b0;
      #1;
      check("t1_hit_stall",  64'(bus.cpu_stall), 64'h0);
      check("t1_hit_rdata",  64'(bus.cpu_rdata), 64'h3333);
      check("t1_stall_cnt",  64'(stall_cycles - base_stall), 64'd4);
      check("t1_no_mem_we",  64'(we_cycles - base_we), 64'd0);

      // 2: write hit then read back, no stall
      base_stall = stall_cycles;
      tick;
      bus.cpu_re    = 1'b0;
      bus.cpu_we    = 1'b1;
      bus.cpu_wdata = 16'hBEEF;
      #1;
      check("t2_wr_stall", 64'(bus.cpu_stall), 64'h0);
      check("t2_wr_rdata", 64'(bus.cpu_rdata), 64'h0);
      tick;
      bus.cpu_we = 1'b0;
      bus.cpu_re = 1'b1;
      #1;
      check("t2_rd_stall", 64'(bus.cpu_stall), 64'h0);
      check("t2_rd_rdata", 64'(bus.cpu_rdata), 64'hBEEF);
      check("t2_stall_cnt", 64'(stall_cycles - base_stall), 64'd0);

      // 3: conflicting read of 0x0032 evicts the dirty line
      tick;
      bus.cpu_addr = 16'h0032;
      #1;
      check("t3_detect_stall", 64'(bus.cpu_stall), 64'h1);
      tick; #1;
      check("t3_wb_we",    64'(bus.mem_we),    64'h1);
      check("t3_wb_re",    64'(bus.mem_re),    64'h0);
      check("t3_wb_addr",  64'(bus.mem_addr),  64'h4);
      check("t3_wb_wdata", bus.mem_wdata,      64'h4444_BEEF_2222_1111);
      bus.mem_rdy = 1'b1;
      tick;
      bus.mem_rdy = 1'b0;
      #1;
      check("t3_alloc_re",   64'(bus.mem_re),   64'h1);
      check("t3_alloc_we",   64'(bus.mem_we),   64'h0);
      check("t3_alloc_addr", 64'(bus.mem_addr), 64'hC);
      bus.mem_rdy   = 1'b1;
      bus.mem_rdata = 64'hDDDD_CCCC_BBBB_AAAA;
      tick;
      bus.mem_rdy = 1'b0;
      #1;
      check("t3_hit_stall", 64'(bus.cpu_stall), 64'h0);
      check("t3_hit_rdata", 64'(bus.cpu_rdata), 64'hCCCC);

      // 4: back to 0x0012 with a clean victim, straight to ALLOC
      tick;
      bus.cpu_addr = 16'h0012;
      #1;
      check("t4_detect_stall", 64'(bus.cpu_stall), 64'h1);
      tick; #1;
      check("t4_alloc_re",   64'(bus.mem_re),   64'h1);
      check("t4_alloc_we",   64'(bus.mem_we),   64'h0);
      check("t4_alloc_addr", 64'(bus.mem_addr), 64'h4);
      bus.mem_rdy   = 1'b1;
      bus.mem_rdata = 64'h4444_BEEF_2222_1111;
      tick;
      bus.mem_rdy = 1'b0;
      #1;
      check("t4_hit_rdata", 64'(bus.cpu_rdata), 64'hBEEF);

      // re and we together act as a write
      tick;
      bus.cpu_we    = 1'b1;
      bus.cpu_wdata = 16'h1234;
      #1;
      check("both_stall", 64'(bus.cpu_stall), 64'h0);
      check("both_rdata", 64'(bus.cpu_rdata), 64'h0);
      tick;
      bus.cpu_we = 1'b0;
      #1;
      check("both_readback", 64'(bus.cpu_rdata), 64'h1234);

      // 5: write-back held 20 cycles with mem_rdy low
      tick;
      bus.cpu_addr = 16'h0032;
      #1;
      check("t5_detect_stall", 64'(bus.cpu_stall), 64'h1);
      for (int i = 0; i < 20; i++) begin
         tick; #1;
         check($sformatf("t5_hold_stall_%0d", i), 64'(bus.cpu_stall), 64'h1);
         check($sformatf("t5_hold_we_%0d", i),    64'(bus.mem_we),    64'h1);
         check($sformatf("t5_hold_addr_%0d", i),  64'(bus.mem_addr),  64'h4);
         check($sformatf("t5_hold_wdata_%0d", i), bus.mem_wdata,      64'h4444_1234_2222_1111);
      end
      bus.mem_rdy = 1'b1;
      tick;
      bus.mem_rdy = 1'b0;
      #1;
      check("t5_alloc_re",   64'(bus.mem_re),   64'h1);
      check("t5_alloc_addr", 64'(bus.mem_addr), 64'hC);

      // 6: asynchronous reset in the middle of ALLOC
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_mem_re", 64'(bus.mem_re),    64'h0);
      check("t6_rst_mem_we", 64'(bus.mem_we),    64'h0);
      check("t6_rst_stall",  64'(bus.cpu_stall), 64'h0);
      tick; tick;
      rst_n        = 1'b1;
      bus.cpu_addr = 16'h0012;
      #1;
      check("t6_remiss_stall", 64'(bus.cpu_stall), 64'h1);
      tick; #1;
      check("t6_alloc_re",   64'(bus.mem_re),   64'h1);
      check("t6_alloc_we",   64'(bus.mem_we),   64'h0);
      check("t6_alloc_addr", 64'(bus.mem_addr), 64'h4);
      bus.mem_rdy   = 1'b1;
      bus.mem_rdata = 64'h4444_3333_2222_1111;
      tick;
      bus.mem_rdy = 1'b0;
      #1;
      check("t6_hit_stall", 64'(bus.cpu_stall), 64'h0);
      check("t6_hit_rdata", 64'(bus.cpu_rdata), 64'h3333);
      tick;
      bus.cpu_re = 1'b0;
      #1;
      check("idle_rdata", 64'(bus.cpu_rdata), 64'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
